// File: rtl/muxn_pkg.sv
// -----------------------------------------------------------------------------
// muxn_pkg
// Shared types and helpers for the N:1 selector pipeline.
//   state_t    : occupancy of the main/skid register pair
//   sel_width  : select/tag width for an n-input selector (never below 1)
//   MAX_NUM_IN : largest supported input count
// -----------------------------------------------------------------------------
package muxn_pkg;

    localparam int MAX_NUM_IN = 16;

    // EMPTY: nothing held, ONE: main holds a word, TWO: main and skid hold words
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    function automatic int sel_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage : muxn_pkg

// File: rtl/muxn_comb.sv
// -----------------------------------------------------------------------------
// muxn_comb
// Purely combinational NUM_IN:1 word selector over a flattened input bus.
// A select value with no matching input (sel >= NUM_IN) falls back to the last
// input, NUM_IN-1.
// Ports:
//   sel      in  SEL_W          source index
//   in_data  in  NUM_IN*WIDTH   input k at bits [k*WIDTH +: WIDTH]
//   out_data out WIDTH          selected word
// -----------------------------------------------------------------------------
module muxn_comb
    import muxn_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = sel_width(NUM_IN)
) (
    input  logic [SEL_W-1:0]        sel,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    output logic [WIDTH-1:0]        out_data
);

    // NOTE: out_data gets a value before the loop so every path assigns it;
    // without that default an unmatched select would infer a latch.
    always_comb begin
        out_data = in_data[(NUM_IN-1)*WIDTH +: WIDTH];
        for (int k = 0; k < NUM_IN; k++) begin
            if (int'(sel) == k) begin
                out_data = in_data[k*WIDTH +: WIDTH];
            end
        end
    end

endmodule : muxn_comb

// File: rtl/muxn_pipe.sv
// -----------------------------------------------------------------------------
// muxn_pipe
// N:1 datapath selector with a registered valid/ready output stage. A main
// register plus a skid register give full throughput while in_ready depends
// only on the state flops. Each output word carries the select that chose it.
//
// Optional build macro: MUXN_RANGE_ERR_EN
//   defined   : accepts with sel >= NUM_IN are consumed but not enqueued, and
//               sel_err pulses for one cycle after such an accept.
//   undefined : sel_err is tied low; out-of-range selects use input NUM_IN-1.
//
// Ports:
//   clk       in  1             rising-edge clock
//   rst_n     in  1             synchronous active-low reset
//   in_valid  in  1             sel/in_data valid
//   in_ready  out 1             block can accept (from state flops only)
//   sel       in  SEL_W         source index, sampled on accept
//   in_data   in  NUM_IN*WIDTH  flattened inputs
//   out_valid out 1             out_data/out_tag valid
//   out_ready in  1             downstream accepts
//   out_data  out WIDTH         selected word
//   out_tag   out SEL_W         select that produced out_data
//   sel_err   out 1             out-of-range select pulse
// -----------------------------------------------------------------------------
module muxn_pipe
    import muxn_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = sel_width(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [SEL_W-1:0]        sel,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_tag,
    output logic                    sel_err
);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   main_data_q, skid_data_q;
    logic [SEL_W-1:0]   main_tag_q,  skid_tag_q;
    logic [WIDTH-1:0]   mux_data;

    logic               accept, emit, enq;
    logic               load_main, main_from_skid, load_skid;

    muxn_comb #(
        .WIDTH  (WIDTH),
        .NUM_IN (NUM_IN),
        .SEL_W  (SEL_W)
    ) u_comb (
        .sel      (sel),
        .in_data  (in_data),
        .out_data (mux_data)
    );

    assign in_ready  = (state_q != TWO);
    assign out_valid = (state_q != EMPTY);
    assign out_data  = main_data_q;
    assign out_tag   = main_tag_q;

    assign accept = in_valid && in_ready;
    assign emit   = out_valid && out_ready;

`ifdef MUXN_RANGE_ERR_EN
    logic sel_in_range;
    logic sel_err_q;

    // An out-of-range accept completes the handshake but stores nothing.
    assign sel_in_range = (int'(sel) < NUM_IN);
    assign enq          = accept && sel_in_range;
    assign sel_err      = sel_err_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sel_err_q <= 1'b0;
        end else begin
            sel_err_q <= accept && !sel_in_range;
        end
    end
`else
    assign enq     = accept;
    assign sel_err = 1'b0;
`endif

    always_comb begin
        state_d        = state_q;
        load_main      = 1'b0;
        main_from_skid = 1'b0;
        load_skid      = 1'b0;
        case (state_q)
            EMPTY: begin
                if (enq) begin
                    state_d   = ONE;
                    load_main = 1'b1;
                end
            end
            ONE: begin
                if (enq && emit) begin
                    load_main = 1'b1;
                end else if (enq) begin
                    state_d   = TWO;
                    load_skid = 1'b1;
                end else if (emit) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                // in_ready is low here, so only an emit can move the state.
                if (emit) begin
                    state_d        = ONE;
                    load_main      = 1'b1;
                    main_from_skid = 1'b1;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, whatever order the statements appear in.
    // The data registers are cleared on reset as well because out_data must
    // read zero straight after reset, not just be ignored while invalid.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= EMPTY;
            main_data_q <= '0;
            main_tag_q  <= '0;
            skid_data_q <= '0;
            skid_tag_q  <= '0;
        end else begin
            state_q <= state_d;
            if (load_main) begin
                main_data_q <= main_from_skid ? skid_data_q : mux_data;
                main_tag_q  <= main_from_skid ? skid_tag_q  : sel;
            end
            if (load_skid) begin
                skid_data_q <= mux_data;
                skid_tag_q  <= sel;
            end
        end
    end

endmodule : muxn_pipe

// File: tb/tb_muxn_pipe.sv
// -----------------------------------------------------------------------------
// tb_muxn_pipe
// Drives a 4-input and a 3-input muxn_pipe in lockstep from shared handshake
// signals and compares both against a queue model: each block holds at most
// two words, in_ready means fewer than two are held, and out_data/out_tag
// show the oldest held word.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_muxn_pipe;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  tag;
    } ent_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic [1:0]   sel;
    logic         out_ready;

    logic [31:0]  w4 [4];
    logic [31:0]  w3 [3];
    logic [127:0] in_data4;
    logic [95:0]  in_data3;

    logic         in_ready4, out_valid4, sel_err4;
    logic [31:0]  out_data4;
    logic [1:0]   out_tag4;
    logic         in_ready3, out_valid3, sel_err3;
    logic [31:0]  out_data3;
    logic [1:0]   out_tag3;

    ent_t         q4[$];
    ent_t         q3[$];
    logic         err3_exp;

    int           n_cmp = 0;
    int           n_bad = 0;

    assign in_data4 = {w4[3], w4[2], w4[1], w4[0]};
    assign in_data3 = {w3[2], w3[1], w3[0]};

    always #5 clk = ~clk;

    muxn_pipe #(.WIDTH(32), .NUM_IN(4)) u_dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready4),
        .sel       (sel),
        .in_data   (in_data4),
        .out_valid (out_valid4),
        .out_ready (out_ready),
        .out_data  (out_data4),
        .out_tag   (out_tag4),
        .sel_err   (sel_err4)
    );

    muxn_pipe #(.WIDTH(32), .NUM_IN(3)) u_dut3 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready3),
        .sel       (sel),
        .in_data   (in_data3),
        .out_valid (out_valid3),
        .out_ready (out_ready),
        .out_data  (out_data3),
        .out_tag   (out_tag3),
        .sel_err   (sel_err3)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic randomize_words();
        for (int i = 0; i < 4; i++) w4[i] = $urandom;
        for (int i = 0; i < 3; i++) w3[i] = $urandom;
    endtask

    // Called just after a falling edge with the next inputs already applied:
    // compares outputs to the model, advances the model, then moves one cycle.
    task automatic step();
        bit   acc4, em4, acc3, em3, new_err3;
        ent_t e;

        check("dut4 in_ready",  32'(in_ready4),  32'(q4.size() < 2));
        check("dut4 out_valid", 32'(out_valid4), 32'(q4.size() > 0));
        if (q4.size() > 0) begin
            check("dut4 out_data", 32'(out_data4), 32'(q4[0].data));
            check("dut4 out_tag",  32'(out_tag4),  32'(q4[0].tag));
        end
        check("dut4 sel_err", 32'(sel_err4), 32'(0));

        check("dut3 in_ready",  32'(in_ready3),  32'(q3.size() < 2));
        check("dut3 out_valid", 32'(out_valid3), 32'(q3.size() > 0));
        if (q3.size() > 0) begin
            check("dut3 out_data", 32'(out_data3), 32'(q3[0].data));
            check("dut3 out_tag",  32'(out_tag3),  32'(q3[0].tag));
        end
        check("dut3 sel_err", 32'(sel_err3), 32'(err3_exp));

        acc4     = in_valid && (q4.size() < 2);
        em4      = out_ready && (q4.size() > 0);
        acc3     = in_valid && (q3.size() < 2);
        em3      = out_ready && (q3.size() > 0);
        new_err3 = 1'b0;

        if (!rst_n) begin
            q4.delete();
            q3.delete();
            err3_exp = 1'b0;
        end else begin
            if (em4) void'(q4.pop_front());
            if (acc4) begin
                e.data = w4[sel];
                e.tag  = sel;
                q4.push_back(e);
            end
            if (em3) void'(q3.pop_front());
            if (acc3) begin
                if (sel < 2'd3) begin
                    e.data = w3[sel];
                    e.tag  = sel;
                    q3.push_back(e);
                end else begin
`ifdef MUXN_RANGE_ERR_EN
                    new_err3 = 1'b1;
`else
                    e.data = w3[2];
                    e.tag  = sel;
                    q3.push_back(e);
`endif
                end
            end
            err3_exp = new_err3;
        end

        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        sel       = 2'd1;
        out_ready = 1'b0;
        err3_exp  = 1'b0;
        randomize_words();

        // Reset held for three edges with in_valid high.
        @(posedge clk);
        @(negedge clk);
        step();
        step();

        rst_n    = 1'b1;
        in_valid = 1'b0;
        check("reset dut4 out_data", 32'(out_data4), 32'(0));
        check("reset dut4 out_tag",  32'(out_tag4),  32'(0));
        check("reset dut3 out_data", 32'(out_data3), 32'(0));
        check("reset dut3 out_tag",  32'(out_tag3),  32'(0));
        step();

        // Back-to-back streaming of four selects with out_ready high.
        w4[0] = 32'h11; w4[1] = 32'h22; w4[2] = 32'h33; w4[3] = 32'h44;
        w3[0] = 32'h11; w3[1] = 32'h22; w3[2] = 32'h33;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            sel      = 2'(i);
            step();
        end
        in_valid = 1'b0;
        step();
        step();

        // Backpressure: three words offered while stalled, then drain.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            randomize_words();
            in_valid = 1'b1;
            sel      = 2'($urandom_range(0, 2));
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) step();

        // Alternating out_ready with continuous offers.
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            randomize_words();
            out_ready = (i % 2) == 0;
            sel       = 2'($urandom_range(0, 3));
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) step();

        // Out-of-range select on the 3-input block.
        w3[2]    = 32'hABCD;
        in_valid = 1'b1;
        sel      = 2'd3;
        step();
`ifdef MUXN_RANGE_ERR_EN
        check("range dut3 out_valid", 32'(out_valid3), 32'(0));
        check("range dut3 sel_err",   32'(sel_err3),   32'(1));
`else
        check("range dut3 out_data", 32'(out_data3), 32'h0000ABCD);
        check("range dut3 out_tag",  32'(out_tag3),  32'(3));
`endif
        in_valid = 1'b0;
        step();
        step();

        // Reset while both blocks hold two words.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 2; i++) begin
            randomize_words();
            sel = 2'($urandom_range(0, 2));
            step();
        end
        check("pre-reset dut4 in_ready", 32'(in_ready4), 32'(0));
        rst_n = 1'b0;
        step();
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) step();

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            if (($urandom % 8) == 0) randomize_words();
            in_valid  = ($urandom % 4) != 0;
            out_ready = ($urandom % 3) != 0;
            sel       = 2'($urandom_range(0, 3));
            rst_n     = ($urandom % 64) != 0;
            step();
        end
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_muxn_pipe

// File: doc/muxn_pipe.md
Name: muxn_pipe

Overview:
Parametrised N:1 datapath selector with a registered valid/ready output stage, for multicycle operand and result-bus selection. Generalises the fixed 4-input combinational mux to NUM_IN inputs of WIDTH bits. A 2-entry skid buffer gives full throughput, with in_ready driven only from flops. The output carries the source index as a tag, so downstream logic knows which input won.

Parameters:
WIDTH, 32, data width of each input and of the output
NUM_IN, 4, number of selectable inputs (2..16, need not be a power of 2)
SEL_W, $clog2(NUM_IN), select and tag width (derived, do not override)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous active-low reset
in_valid  in  1  sel/in_data valid this cycle
in_ready  out  1  block can accept; function of state flops only
sel  in  SEL_W  source index; sampled on accept
in_data  in  NUM_IN*WIDTH  flattened inputs; input k at bits [k*WIDTH +: WIDTH]
out_valid  out  1  out_data/out_tag valid
out_ready  in  1  downstream accepts
out_data  out  WIDTH  selected word
out_tag  out  SEL_W  index that produced out_data
sel_err  out  1  out-of-range select pulse (feature only, else tied 0)

Behaviour:
- Accept: in_valid && in_ready at a clk edge. Emit: out_valid && out_ready at a clk edge.
- Reset values (rst_n low at a clk edge):
  - state = EMPTY
  - out_valid = 0, out_data = 0, out_tag = 0
  - skid register = 0
  - in_ready = 1 from the first cycle after reset
  - sel_err = 0
- Reset mid-transfer discards both entries. No output is produced for data accepted before the reset edge.
- States, held in main and skid registers:
  - EMPTY: in_ready = 1, out_valid = 0.
  - ONE: main register holds data. in_ready = 1, out_valid = 1.
  - TWO: main and skid both hold data. in_ready = 0, out_valid = 1.
- Transitions:
  - EMPTY, accept -> ONE. main <= in_data[sel], tag <= sel.
  - ONE, accept without emit -> TWO. New word goes to skid.
  - ONE, accept and emit in the same cycle -> ONE. main <= new word.
  - ONE, emit without accept -> EMPTY.
  - TWO, emit -> ONE. main <= skid.
  - TWO, no emit -> TWO, holding.
- Latency: 1 cycle from accept to out_valid when the output path is empty.
- Throughput: 1 word per cycle when out_ready is held high.
- Ordering: strict FIFO, and no word is dropped or duplicated.
- Holding: out_data and out_tag stay stable while out_valid && !out_ready.
- sel is ignored when in_valid = 0.
- Out-of-range sel (sel >= NUM_IN, possible only when NUM_IN is not a power of 2): without the feature, selects input NUM_IN-1. This matches the existing 4-way default-arm convention.

Optional Feature:
MUXN_RANGE_ERR_EN
- Defined:
  - An accept with sel >= NUM_IN is consumed (in_ready handshake completes), but nothing is enqueued and the state is unchanged.
  - sel_err pulses high for exactly one cycle, the cycle after that accept.
- Undefined: sel_err is tied to 0 and out-of-range selects clamp to input NUM_IN-1.

Decomposition:
- Package muxn_pkg:
  - state enum {EMPTY, ONE, TWO}, 2-bit encoding
  - function sel_width(n) returning $clog2(n), minimum 1
  - localparam MAX_NUM_IN = 16
- Sub-module muxn_comb: purely combinational NUM_IN:1 selection from the flattened bus, including the clamp rule. It is instantiated once in muxn_pipe and is reusable on its own.
- muxn_pipe contains only the state machine and the registers.

Test Plan:
- Reset: hold rst_n = 0 for 3 cycles with in_valid = 1 -> out_valid = 0, out_data = 0, out_tag = 0, in_ready = 1 on the first cycle after release.
- Streaming: NUM_IN = 4, WIDTH = 32, inputs 0x11/0x22/0x33/0x44, sel sequence 0,1,2,3 back-to-back, out_ready = 1 -> out_data 0x11, 0x22, 0x33, 0x44 with tags 0..3 on consecutive cycles, 1-cycle latency.
- Backpressure: out_ready = 0 with 3 words offered -> 2 accepted, in_ready = 0 after the second, out_data holds the first. Raising out_ready -> both words emerge in order, then in_ready = 1.
- Simultaneous accept and emit in ONE: 10 cycles of alternating out_ready -> no loss or duplication (scoreboard), and in_ready never drops in ONE.
- Out-of-range: NUM_IN = 3, sel = 3, input 2 = 0xABCD.
  - Without the macro -> out_data = 0xABCD, out_tag = 3.
  - With MUXN_RANGE_ERR_EN -> no output, sel_err high for 1 cycle.
- Reset mid-transfer: assert rst_n = 0 while in TWO -> next cycle out_valid = 0 and in_ready = 1, and the stale words never appear.
